// File: rtl/fixed_cast_pkg.sv
// Shared definitions for fixed-point cast stages.
//   round_mode_e : rounding policy applied before saturation
//   sat_clamp    : clamps a sign-extended value to the signed range of an
//                  out_w-bit word; callers keep the low out_w bits
package fixed_cast_pkg;

    typedef enum logic {
        ROUND_FLOOR   = 1'b0,
        ROUND_HALF_UP = 1'b1
    } round_mode_e;

    // Working width for clamping; wide enough for any cast stage in use.
    localparam int CAST_W = 64;

    function automatic logic signed [CAST_W-1:0] sat_clamp(
        input logic signed [CAST_W-1:0] value,
        input int                       out_w
    );
        logic signed [CAST_W-1:0] max_v;
        logic signed [CAST_W-1:0] min_v;
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 1));
        if (value > max_v) begin
            sat_clamp = max_v;
        end else if (value < min_v) begin
            sat_clamp = min_v;
        end else begin
            sat_clamp = value;
        end
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer with fully registered outputs.
//   clk, rst (async, active-low)
//   data_in / data_in_valid / data_in_ready    : upstream side, ready registered
//   data_out / data_out_valid / data_out_ready : downstream side, data held
//                                                stable while stalled
module skid_buffer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);

    logic                  main_valid_q, main_valid_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  ready_q, ready_d;
    logic                  in_fire;
    logic                  out_fire;

    always_comb begin
        in_fire      = data_in_valid & ready_q;
        out_fire     = main_valid_q & data_out_ready;
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
            // Ready is low while the skid slot is full, so only draining happens.
            if (out_fire) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (!main_valid_q || out_fire) begin
                main_valid_d = 1'b1;
                main_data_d  = data_in;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = data_in;
            end
        end else if (out_fire) begin
            main_valid_d = 1'b0;
        end
        ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ready_d;
        end
    end

    assign data_in_ready  = ready_q;
    assign data_out       = main_data_q;
    assign data_out_valid = main_valid_q;

endmodule

// File: rtl/fixed_requantize_pipe.sv
// Streaming fixed-point requantizer: shift to the output fraction width,
// round (floor or half-up), saturate per lane, then hand off through a skid.
//   clk, rst (async, active-low)
//   data_in_0 / _valid / _ready   : N lanes of IN_W-bit signed input, ready registered
//   data_out_0 / _valid / _ready  : N lanes of OUT_W-bit signed output
//   sat_count / sat_clear         : sticky count of beats with any clamped lane
module fixed_requantize_pipe
    import fixed_cast_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0       = 16,
    parameter int DATA_IN_0_PRECISION_1       = 8,
    parameter int DATA_OUT_0_PRECISION_0      = 8,
    parameter int DATA_OUT_0_PRECISION_1      = 4,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int ROUND_MODE                  = 1,
    parameter int SAT_CNT_WIDTH               = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic [DATA_IN_0_PRECISION_0*DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0] data_in_0,
    input  logic data_in_0_valid,
    output logic data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0*DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0] data_out_0,
    output logic data_out_0_valid,
    input  logic data_out_0_ready,
    output logic [SAT_CNT_WIDTH-1:0] sat_count,
    input  logic sat_clear
);

    localparam int IN_W  = DATA_IN_0_PRECISION_0;
    localparam int OUT_W = DATA_OUT_0_PRECISION_0;
    localparam int N     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int SH    = DATA_IN_0_PRECISION_1 - DATA_OUT_0_PRECISION_1;
    // One guard bit absorbs the rounding carry; left shifts need room for -SH bits.
    localparam int RW    = (SH > 0) ? IN_W + 1 : IN_W - SH;
    localparam round_mode_e RMODE = (ROUND_MODE != 0) ? ROUND_HALF_UP : ROUND_FLOOR;

    logic                     in_ready_q, in_ready_d;
    logic [2:0]               cnt_q, cnt_d;
    logic                     s1_valid_q, s1_valid_d;
    logic [N*RW-1:0]          s1_data_q, s1_data_d;
    logic                     s2_valid_q, s2_valid_d;
    logic [N*OUT_W-1:0]       s2_data_q, s2_data_d;
    logic                     s2_sat_q, s2_sat_d;
    logic [SAT_CNT_WIDTH-1:0] sat_count_q, sat_count_d;

    logic [N*RW-1:0]    rnd_all;
    logic [N*OUT_W-1:0] sat_all;
    logic [N-1:0]       lane_hit;
    logic               skid_in_ready;
    logic               in_fire, out_fire, s1_adv, s2_adv, s2_open;

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic signed [IN_W-1:0]   lane_in;
        logic signed [RW-1:0]     lane_ext;
        logic signed [RW-1:0]     lane_rnd;
        logic signed [RW-1:0]     lane_s1;
        logic signed [CAST_W-1:0] lane_wide;
        logic signed [CAST_W-1:0] lane_clamped;

        assign lane_in  = data_in_0[gi*IN_W +: IN_W];
        assign lane_ext = RW'(lane_in);
        if (SH > 0) begin : g_down
            if (RMODE == ROUND_HALF_UP) begin : g_half_up
                localparam logic signed [RW-1:0] HALF = RW'(1) <<< (SH - 1);
                assign lane_rnd = (lane_ext + HALF) >>> SH;
            end else begin : g_floor
                assign lane_rnd = lane_ext >>> SH;
            end
        end else begin : g_up
            assign lane_rnd = lane_ext <<< (-SH);
        end
        assign rnd_all[gi*RW +: RW] = lane_rnd;

        assign lane_s1      = s1_data_q[gi*RW +: RW];
        assign lane_wide    = CAST_W'(lane_s1);
        assign lane_clamped = sat_clamp(lane_wide, OUT_W);
        assign sat_all[gi*OUT_W +: OUT_W] = lane_clamped[OUT_W-1:0];
        assign lane_hit[gi] = (lane_clamped != lane_wide);
    end

    always_comb begin
        in_fire  = data_in_0_valid & in_ready_q;
        out_fire = data_out_0_valid & data_out_0_ready;
        s2_open  = ~s2_valid_q | skid_in_ready;
        s2_adv   = s2_valid_q & skid_in_ready;
        s1_adv   = s1_valid_q & s2_open;

        // Occupancy tracking guarantees S1 can always take an accepted beat:
        // a blocked S1 implies S1+S2+both skid entries are full, i.e. count 4.
        s1_valid_d = in_fire | (s1_valid_q & ~s2_open);
        s1_data_d  = in_fire ? rnd_all : s1_data_q;
        s2_valid_d = s1_adv | (s2_valid_q & ~skid_in_ready);
        s2_data_d  = s1_adv ? sat_all : s2_data_q;
        s2_sat_d   = s1_adv ? (|lane_hit) : s2_sat_q;

        cnt_d      = cnt_q + {2'b00, in_fire} - {2'b00, out_fire};
        in_ready_d = (cnt_d < 3'd4);

        sat_count_d = sat_count_q;
        if (sat_clear) begin
            sat_count_d = '0;
        end else if (s2_adv && s2_sat_q && !(&sat_count_q)) begin
            sat_count_d = sat_count_q + SAT_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_q  <= 1'b0;
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_sat_q    <= 1'b0;
            sat_count_q <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            cnt_q       <= cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_sat_q    <= s2_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    skid_buffer #(
        .DATA_WIDTH(OUT_W * N)
    ) u_out_skid (
        .clk           (clk),
        .rst           (rst),
        .data_in       (s2_data_q),
        .data_in_valid (s2_valid_q),
        .data_in_ready (skid_in_ready),
        .data_out      (data_out_0),
        .data_out_valid(data_out_0_valid),
        .data_out_ready(data_out_0_ready)
    );

    assign data_in_0_ready = in_ready_q;
    assign sat_count       = sat_count_q;

endmodule

// File: tb/tb_fixed_requantize_pipe.sv
// Bench for fixed_requantize_pipe (IN 16/8, OUT 8/4, N=4). Two instances share
// the stimulus: dut rounds half-up, dut_floor truncates.
module tb_fixed_requantize_pipe;

    localparam int SAT_BEATS = 65539;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] din;
    logic        din_valid;
    logic        din_ready, din_ready_f;
    logic [31:0] dout, dout_f;
    logic        dout_valid, dout_valid_f;
    logic        dout_ready;
    logic [15:0] sat_count, sat_count_f;
    logic        sat_clear;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_q[$];
    logic [31:0] got_f_q[$];

    always #5 clk = ~clk;

    fixed_requantize_pipe #(.ROUND_MODE(1)) dut (
        .clk(clk), .rst(rst),
        .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(din_ready),
        .data_out_0(dout), .data_out_0_valid(dout_valid), .data_out_0_ready(dout_ready),
        .sat_count(sat_count), .sat_clear(sat_clear)
    );

    fixed_requantize_pipe #(.ROUND_MODE(0)) dut_floor (
        .clk(clk), .rst(rst),
        .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(din_ready_f),
        .data_out_0(dout_f), .data_out_0_valid(dout_valid_f), .data_out_0_ready(dout_ready),
        .sat_count(sat_count_f), .sat_clear(sat_clear)
    );

    // Collects beats that will transfer on the coming rising edge.
    always @(negedge clk) begin
        if (rst) begin
            if (dout_valid && dout_ready) got_q.push_back(dout);
            if (dout_valid_f && dout_ready) got_f_q.push_back(dout_f);
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: real-valued input scaled to output LSBs, floored (after +0.5
    // for half-up), then clamped to the signed 8-bit range.
    function automatic logic [7:0] model_lane(input logic [15:0] x, input bit half_up,
                                              output bit sat);
        int  xi;
        int  q;
        real v;
        xi = int'($signed(x));
        v  = real'(xi) / 16.0;
        if (half_up) v = v + 0.5;
        q   = int'($floor(v));
        sat = 1'b0;
        if (q > 127) begin
            q = 127;  sat = 1'b1;
        end else if (q < -128) begin
            q = -128; sat = 1'b1;
        end
        return q[7:0];
    endfunction

    function automatic logic [31:0] model_beat(input logic [63:0] b, input bit half_up,
                                               output bit any_sat);
        logic [31:0] r;
        bit          s;
        any_sat = 1'b0;
        for (int l = 0; l < 4; l++) begin
            r[l*8 +: 8] = model_lane(b[l*16 +: 16], half_up, s);
            any_sat |= s;
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_lane();
        logic [15:0] v;
        int          sel;
        sel = $urandom_range(0, 3);
        v   = 16'($urandom);
        case (sel)
            1: v = 16'($urandom_range(0, 4095)) - 16'd2048;
            2: v = ((16'($urandom_range(0, 255)) - 16'd128) << 4) | 16'h0008;
            3: v = 16'($urandom_range(0, 255)) - 16'd128;
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [63:0] rand_beat();
        logic [63:0] b;
        for (int l = 0; l < 4; l++) b[l*16 +: 16] = rand_lane();
        return b;
    endfunction

    task automatic reset_dut();
        din_valid  = 1'b0;
        din        = '0;
        sat_clear  = 1'b0;
        dout_ready = 1'b0;
        rst        = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        got_q.delete();
        got_f_q.delete();
    endtask

    task automatic test_reset();
        din_valid = 1'b0; din = '0; sat_clear = 1'b0; dout_ready = 1'b0; rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b0 || sat_count !== 16'h0 || dout !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b ready=%b sat=%h data=%h, required 0/0/0000/00000000",
                     dout_valid, din_ready, sat_count, dout);
        end
        checks++;
        if (din_ready_f !== 1'b0 || sat_count_f !== 16'h0 || dout_valid_f !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_floor: ready=%b sat=%h valid=%b, required 0/0000/0",
                     din_ready_f, sat_count_f, dout_valid_f);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (din_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: ready=%b required 0", din_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: ready=%b required 1", din_ready);
        end
        @(posedge clk); #1;
        $display("reset: outputs idle, ready rose one cycle after release");
    endtask

    task automatic test_known_vectors();
        got_q.delete(); got_f_q.delete();
        dout_ready = 1'b1;
        din = {16'hFFE8, 16'hFFF8, 16'h0188, 16'h0180};
        din_valid = 1'b1;
        @(posedge clk); #1;          // accepted on this edge (ready was high)
        din_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); @(negedge clk);
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: valid=%b one edge after S1, required 0", dout_valid);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (dout_valid !== 1'b1 || dout !== 32'hFF00_1918) begin
            errors++;
            $display("FAIL vec_half_up: valid=%b data=%h, required 1 ff001918", dout_valid, dout);
        end
        checks++;
        if (dout_valid_f !== 1'b1 || dout_f !== 32'hFEFF_1818) begin
            errors++;
            $display("FAIL vec_floor: valid=%b data=%h, required 1 feff1818", dout_valid_f, dout_f);
        end
        $display("beat in=%h out=%h floor_out=%h", 64'hFFE8_FFF8_0188_0180, dout, dout_f);
        checks++;
        if (sat_count !== 16'h0) begin
            errors++;
            $display("FAIL sat_none: sat_count=%h required 0000", sat_count);
        end

        @(posedge clk); #1;
        din = {16'h0100, 16'h0000, 16'h9C00, 16'h7FFF};
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        for (int w = 0; w < 10 && !dout_valid; w++) @(negedge clk);
        if (!dout_valid) @(negedge clk);
        checks++;
        if (dout_valid !== 1'b1 || dout !== 32'h1000_807F) begin
            errors++;
            $display("FAIL vec_saturate: valid=%b data=%h, required 1 1000807f", dout_valid, dout);
        end
        checks++;
        if (dout_f !== 32'h1000_807F) begin
            errors++;
            $display("FAIL vec_saturate_floor: data=%h required 1000807f", dout_f);
        end
        $display("beat in=%h out=%h floor_out=%h", 64'h0100_0000_9C00_7FFF, dout, dout_f);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sat_count !== 16'h1) begin
            errors++;
            $display("FAIL sat_one_beat: sat_count=%h required 0001", sat_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [63:0] beats[30];
        logic [31:0] exp;
        bit          s;
        int          miss;
        got_q.delete(); got_f_q.delete();
        dout_ready = 1'b1;
        miss = 0;
        for (int i = 0; i < 30; i++) beats[i] = rand_beat();
        for (int i = 0; i < 30; i++) begin
            din = beats[i];
            din_valid = 1'b1;
            @(negedge clk);
            if (!din_ready) miss++;
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        checks++;
        if (miss !== 0) begin
            errors++;
            $display("FAIL b2b_throughput: ready low in %0d cycles, required 0", miss);
        end
        for (int w = 0; w < 20 && got_q.size() < 30; w++) @(negedge clk);
        checks++;
        if (got_q.size() !== 30) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats, required 30", got_q.size());
        end
        for (int i = 0; i < 30 && i < got_q.size(); i++) begin
            exp = model_beat(beats[i], 1'b1, s);
            checks++;
            if (got_q[i] !== exp) begin
                errors++;
                $display("FAIL b2b_beat%0d: got %h required %h (in %h)", i, got_q[i], exp, beats[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [63:0] beats[20];
        logic [63:0] base;
        logic [31:0] exp, prev_data;
        bit          s, prev_stall;
        int          idx, cyc, acc_low;
        reset_dut();
        base = rand_beat();
        for (int i = 0; i < 20; i++)
            for (int l = 0; l < 4; l++)
                beats[i][l*16 +: 16] = base[l*16 +: 16] + 16'(i * 16'h0321) + 16'($urandom_range(0, 15));
        idx = 0; cyc = 0; acc_low = 0; prev_stall = 1'b0; prev_data = '0;
        while (idx < 20 && cyc < 400) begin
            din = beats[idx];
            din_valid = 1'b1;
            dout_ready = (cyc < 10) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (din_valid && din_ready) begin
                if (cyc < 10) acc_low++;
                idx++;
            end
            if (prev_stall) begin
                checks++;
                if (dout_valid !== 1'b1 || dout !== prev_data) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%b data=%h, required 1 %h", dout_valid, dout, prev_data);
                end
            end
            prev_stall = dout_valid && !dout_ready;
            prev_data  = dout;
            @(posedge clk); #1;
            cyc++;
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        checks++;
        if (acc_low !== 4) begin
            errors++;
            $display("FAIL capacity: accepted %0d while output stalled, required 4", acc_low);
        end
        checks++;
        if (idx !== 20) begin
            errors++;
            $display("FAIL bp_accept_timeout: accepted %0d, required 20", idx);
        end
        for (int w = 0; w < 40 && got_q.size() < 20; w++) @(negedge clk);
        checks++;
        if (got_q.size() !== 20 || got_f_q.size() !== 20) begin
            errors++;
            $display("FAIL bp_count: got %0d/%0d beats, required 20", got_q.size(), got_f_q.size());
        end
        for (int i = 0; i < 20 && i < got_q.size() && i < got_f_q.size(); i++) begin
            exp = model_beat(beats[i], 1'b1, s);
            checks++;
            if (got_q[i] !== exp) begin
                errors++;
                $display("FAIL bp_beat%0d: got %h required %h", i, got_q[i], exp);
            end
            exp = model_beat(beats[i], 1'b0, s);
            checks++;
            if (got_f_q[i] !== exp) begin
                errors++;
                $display("FAIL bp_floor_beat%0d: got %h required %h", i, got_f_q[i], exp);
            end
            $display("bp beat %0d in=%h out=%h floor_out=%h", i, beats[i], got_q[i], got_f_q[i]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_burst();
        logic [63:0] fresh[2];
        logic [31:0] exp;
        bit          s;
        int          exp_sat;
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            din = {4{16'h7FFF - 16'(i)}};
            din_valid = 1'b1;
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        checks++;
        if (dout_valid !== 1'b1 || sat_count !== 16'h1) begin
            errors++;
            $display("FAIL pre_reset: valid=%b sat=%h, required 1 0001", dout_valid, sat_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b0 || sat_count !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: valid=%b ready=%b sat=%h, required 0 0 0000",
                     dout_valid, din_ready, sat_count);
        end
        @(posedge clk); #1 rst = 1'b1;
        got_q.delete(); got_f_q.delete();
        dout_ready = 1'b1;
        @(posedge clk); #1;
        exp_sat = 0;
        for (int i = 0; i < 2; i++) begin
            for (int l = 0; l < 4; l++) fresh[i][l*16 +: 16] = 16'($urandom_range(0, 4000)) - 16'd2000;
            exp = model_beat(fresh[i], 1'b1, s);
            if (s) exp_sat++;
            din = fresh[i];
            din_valid = 1'b1;
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        for (int w = 0; w < 20 && got_q.size() < 2; w++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (got_q.size() !== 2) begin
            errors++;
            $display("FAIL post_reset_count: got %0d beats, required 2", got_q.size());
        end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            exp = model_beat(fresh[i], 1'b1, s);
            checks++;
            if (got_q[i] !== exp) begin
                errors++;
                $display("FAIL post_reset_beat%0d: got %h required %h", i, got_q[i], exp);
            end
            $display("post-reset beat %0d in=%h out=%h", i, fresh[i], got_q[i]);
        end
        checks++;
        if (sat_count !== 16'(exp_sat)) begin
            errors++;
            $display("FAIL post_reset_sat: sat_count=%h required %h", sat_count, 16'(exp_sat));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sat_counter();
        int sent, cyc;
        reset_dut();
        dout_ready = 1'b1;
        din = {4{16'h7FFF}};
        din_valid = 1'b1;
        sent = 0; cyc = 0;
        while (sent < SAT_BEATS && cyc < SAT_BEATS + 200) begin
            @(negedge clk);
            if (din_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        din_valid = 1'b0;
        checks++;
        if (sent !== SAT_BEATS) begin
            errors++;
            $display("FAIL sat_stream_timeout: sent %0d, required %0d", sent, SAT_BEATS);
        end
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sat_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_sticky: sat_count=%h required ffff", sat_count);
        end
        $display("sat stream: %0d saturating beats, sat_count=%h", sent, sat_count);
        @(posedge clk); #1;
        sat_clear = 1'b1;
        din = {4{16'h8000}};
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 sat_clear = 1'b0;
        @(negedge clk);
        checks++;
        if (sat_count !== 16'h0) begin
            errors++;
            $display("FAIL clear_priority: sat_count=%h required 0000", sat_count);
        end
        @(posedge clk); #1;
        din = {4{16'h8000}};
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sat_count !== 16'h1) begin
            errors++;
            $display("FAIL count_after_clear: sat_count=%h required 0001", sat_count);
        end
        got_q.delete(); got_f_q.delete();
    endtask

    initial begin
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        sat_clear  = 1'b0;
        test_reset();
        test_known_vectors();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_burst();
        test_sat_counter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
